// File: rtl/control_sequencer.sv
// control_sequencer: opcode decoder and T-step sequencer for the bus-based CPU.
// Issues one control word per step. Each instruction ends on its own final
// step. The design has a latched branch condition, a sticky illegal-opcode
// flag, a run-enable freeze, and a HALTED state that only reset can leave.
module control_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int OPCODE_WIDTH  = 4,
    parameter int CONTROL_WIDTH = 17,
    parameter int T_WIDTH       = 3
) (
    input  logic                     i_CLOCK,
    input  logic                     i_RESET,
    input  logic                     i_ENABLE,
    input  logic [DATA_WIDTH-1:0]    i_IR_DATA,
    input  logic                     i_ZERO_FLAG,
    input  logic                     i_CARRY_FLAG,
    input  logic                     i_NEG_FLAG,
    output logic                     o_CLEAR,
    output logic                     o_CLEAR_n,
    output logic [CONTROL_WIDTH-1:0] o_CONTROL_SIGNALS,
    output logic [T_WIDTH-1:0]       o_T_CYCLE,
    output logic                     o_INSTR_DONE,
    output logic                     o_HALTED,
    output logic                     o_ILLEGAL
);
    // Control-word bit positions. These are the shared definitions. Bits 15-16 are reserved.
    localparam int c_PC_OUT       = 0;
    localparam int c_MAR_IN       = 1;
    localparam int c_RAM_OUT      = 2;
    localparam int c_IR_IN        = 3;
    localparam int c_PC_INC       = 4;
    localparam int c_A_IN         = 5;
    localparam int c_B_IN         = 6;
    localparam int c_ALU_OUT      = 7;
    localparam int c_FLAGS_UPDATE = 8;
    localparam int c_ALU_SUB      = 9;
    localparam int c_A_OUT        = 10;
    localparam int c_RAM_IN       = 11;
    localparam int c_JUMP         = 12;
    localparam int c_OUT_IN       = 13;
    localparam int c_HALT         = 14;

    localparam logic [CONTROL_WIDTH-1:0] cw_pc_out  = CONTROL_WIDTH'(1) << c_PC_OUT;
    localparam logic [CONTROL_WIDTH-1:0] cw_mar_in  = CONTROL_WIDTH'(1) << c_MAR_IN;
    localparam logic [CONTROL_WIDTH-1:0] cw_ram_out = CONTROL_WIDTH'(1) << c_RAM_OUT;
    localparam logic [CONTROL_WIDTH-1:0] cw_ir_in   = CONTROL_WIDTH'(1) << c_IR_IN;
    localparam logic [CONTROL_WIDTH-1:0] cw_pc_inc  = CONTROL_WIDTH'(1) << c_PC_INC;
    localparam logic [CONTROL_WIDTH-1:0] cw_a_in    = CONTROL_WIDTH'(1) << c_A_IN;
    localparam logic [CONTROL_WIDTH-1:0] cw_b_in    = CONTROL_WIDTH'(1) << c_B_IN;
    localparam logic [CONTROL_WIDTH-1:0] cw_alu_out = CONTROL_WIDTH'(1) << c_ALU_OUT;
    localparam logic [CONTROL_WIDTH-1:0] cw_flags   = CONTROL_WIDTH'(1) << c_FLAGS_UPDATE;
    localparam logic [CONTROL_WIDTH-1:0] cw_alu_sub = CONTROL_WIDTH'(1) << c_ALU_SUB;
    localparam logic [CONTROL_WIDTH-1:0] cw_a_out   = CONTROL_WIDTH'(1) << c_A_OUT;
    localparam logic [CONTROL_WIDTH-1:0] cw_ram_in  = CONTROL_WIDTH'(1) << c_RAM_IN;
    localparam logic [CONTROL_WIDTH-1:0] cw_jump    = CONTROL_WIDTH'(1) << c_JUMP;
    localparam logic [CONTROL_WIDTH-1:0] cw_out_in  = CONTROL_WIDTH'(1) << c_OUT_IN;
    localparam logic [CONTROL_WIDTH-1:0] cw_halt    = CONTROL_WIDTH'(1) << c_HALT;

    localparam logic [OPCODE_WIDTH-1:0] op_lda  = OPCODE_WIDTH'(4'h1);
    localparam logic [OPCODE_WIDTH-1:0] op_add  = OPCODE_WIDTH'(4'h2);
    localparam logic [OPCODE_WIDTH-1:0] op_sub  = OPCODE_WIDTH'(4'h3);
    localparam logic [OPCODE_WIDTH-1:0] op_ldi  = OPCODE_WIDTH'(4'h4);
    localparam logic [OPCODE_WIDTH-1:0] op_addi = OPCODE_WIDTH'(4'h5);
    localparam logic [OPCODE_WIDTH-1:0] op_subi = OPCODE_WIDTH'(4'h6);
    localparam logic [OPCODE_WIDTH-1:0] op_sta  = OPCODE_WIDTH'(4'h7);
    localparam logic [OPCODE_WIDTH-1:0] op_jmp  = OPCODE_WIDTH'(4'h8);
    localparam logic [OPCODE_WIDTH-1:0] op_jz   = OPCODE_WIDTH'(4'h9);
    localparam logic [OPCODE_WIDTH-1:0] op_jc   = OPCODE_WIDTH'(4'hA);
    localparam logic [OPCODE_WIDTH-1:0] op_jn   = OPCODE_WIDTH'(4'hB);
    localparam logic [OPCODE_WIDTH-1:0] op_out  = OPCODE_WIDTH'(4'hE);
    localparam logic [OPCODE_WIDTH-1:0] op_hlt  = OPCODE_WIDTH'(4'hF);

    typedef enum logic {st_run, st_halted} state_t;

    state_t                   state_q, state_next;
    logic [T_WIDTH-1:0]       t_q, t_next, last_step;
    logic                     branch_q, branch_next;
    logic                     illegal_q, illegal_next;
    logic                     flag_sel;
    logic [CONTROL_WIDTH-1:0] word;
    logic                     done;
    logic [OPCODE_WIDTH-1:0]  opcode;

    assign opcode = i_IR_DATA[DATA_WIDTH-1 -: OPCODE_WIDTH];

    // The operand bits below the opcode field are not used by decode.
    if (DATA_WIDTH > OPCODE_WIDTH) begin : g_ir_low
        logic unused_ir_low;
        assign unused_ir_low = ^i_IR_DATA[DATA_WIDTH-OPCODE_WIDTH-1:0];
    end

    // State, step counter, branch latch and sticky illegal flag. Reset overrides every other input.
    always_ff @(posedge i_CLOCK) begin
        if (i_RESET) begin
            state_q   <= st_run;
            t_q       <= '0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_next;
            t_q       <= t_next;
            branch_q  <= branch_next;
            illegal_q <= illegal_next;
        end
    end

    // Decode of the opcode and step into the control word, the end-of-instruction flag and the next state.
    always_comb begin
        word         = '0;
        done         = 1'b0;
        t_next       = t_q;
        state_next   = state_q;
        branch_next  = branch_q;
        illegal_next = illegal_q;

        case (opcode)
            op_add, op_sub:                        last_step = T_WIDTH'(5);
            op_lda, op_addi, op_subi, op_sta:      last_step = T_WIDTH'(4);
            op_ldi, op_jmp, op_jz, op_jc, op_jn:   last_step = T_WIDTH'(3);
            default:                               last_step = T_WIDTH'(2);
        endcase

        case (opcode)
            op_jz:   flag_sel = i_ZERO_FLAG;
            op_jc:   flag_sel = i_CARRY_FLAG;
            op_jn:   flag_sel = i_NEG_FLAG;
            default: flag_sel = 1'b0;
        endcase

        if (state_q == st_halted) begin
            word   = cw_halt;
            t_next = '0;
        end else if (i_ENABLE) begin
            if (t_q > last_step) begin
                // An out-of-range step is recovered by a silent return to fetch.
                t_next = '0;
            end else begin
                done   = (t_q == last_step);
                t_next = done ? '0 : t_q + T_WIDTH'(1);
                if (t_q == T_WIDTH'(0)) begin
                    word = cw_pc_out | cw_mar_in;
                end else if (t_q == T_WIDTH'(1)) begin
                    word = cw_ram_out | cw_ir_in | cw_pc_inc;
                end else begin
                    case (opcode)
                        op_lda: case (t_q)
                            T_WIDTH'(2): word = cw_pc_out | cw_mar_in;
                            T_WIDTH'(3): word = cw_ram_out | cw_mar_in;
                            default:     word = cw_pc_inc | cw_ram_out | cw_a_in;
                        endcase
                        op_add, op_sub: case (t_q)
                            T_WIDTH'(2): word = cw_pc_out | cw_mar_in;
                            T_WIDTH'(3): word = cw_ram_out | cw_mar_in;
                            T_WIDTH'(4): word = cw_ram_out | cw_b_in;
                            default:     word = cw_pc_inc | cw_alu_out | cw_a_in | cw_flags
                                                | ((opcode == op_sub) ? cw_alu_sub : '0);
                        endcase
                        op_ldi: case (t_q)
                            T_WIDTH'(2): word = cw_pc_out | cw_mar_in;
                            default:     word = cw_pc_inc | cw_ram_out | cw_a_in;
                        endcase
                        op_addi, op_subi: case (t_q)
                            T_WIDTH'(2): word = cw_pc_out | cw_mar_in;
                            T_WIDTH'(3): word = cw_pc_inc | cw_ram_out | cw_b_in;
                            default:     word = cw_alu_out | cw_a_in | cw_flags
                                                | ((opcode == op_subi) ? cw_alu_sub : '0);
                        endcase
                        op_sta: case (t_q)
                            T_WIDTH'(2): word = cw_pc_out | cw_mar_in;
                            T_WIDTH'(3): word = cw_ram_out | cw_mar_in;
                            default:     word = cw_pc_inc | cw_a_out | cw_ram_in;
                        endcase
                        op_jmp: case (t_q)
                            T_WIDTH'(2): word = cw_pc_out | cw_mar_in;
                            default:     word = cw_pc_inc | cw_ram_out | cw_jump;
                        endcase
                        op_jz, op_jc, op_jn: begin
                            // The flag is captured at T2. T3 sees only the latch, so later flag changes do not matter.
                            if (t_q == T_WIDTH'(2)) begin
                                branch_next = flag_sel;
                                word        = flag_sel ? (cw_pc_out | cw_mar_in) : '0;
                            end else begin
                                word = branch_q ? (cw_pc_inc | cw_ram_out | cw_jump) : cw_pc_inc;
                            end
                        end
                        op_out: word = cw_a_out | cw_out_in;
                        op_hlt: begin
                            word       = cw_halt;
                            state_next = st_halted;
                        end
                        default: illegal_next = 1'b1;
                    endcase
                end
            end
        end

        if (i_RESET) begin
            word = '0;
            done = 1'b0;
        end
    end

    assign o_CLEAR           = i_RESET;
    assign o_CLEAR_n         = ~i_RESET;
    assign o_CONTROL_SIGNALS = word;
    assign o_T_CYCLE         = t_q;
    assign o_INSTR_DONE      = done;
    assign o_HALTED          = (state_q == st_halted);
    assign o_ILLEGAL         = illegal_q;
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Parametrised successor to the fixed 7-step control unit.
- Decodes the opcode field of the instruction register and issues one control word per T-cycle.
- Instructions have variable length: the step counter returns to fetch on each instruction's final step instead of always running 7 steps.
- Adds a latched branch condition, a negative-flag jump, a sticky illegal-opcode flag, a run-enable freeze, a latched HALTED state and status outputs.
- Sits between the IR/flags register and every bus-attached unit.

Parameters:
- DATA_WIDTH, 8, IR width; opcode is i_IR_DATA[DATA_WIDTH-1 -: OPCODE_WIDTH].
- OPCODE_WIDTH, 4, opcode field width; must be at least 4 and at most DATA_WIDTH.
- CONTROL_WIDTH, 17, control word width; bit positions come from the shared control-signal definitions (c_PC_OUT, c_MAR_IN, ..., c_HALT).
- T_WIDTH, 3, step counter width; must hold the longest instruction (6 steps, T0..T5).

Ports:
- i_CLOCK  in  1  system clock, all state on rising edge.
- i_RESET  in  1  synchronous, active-high reset.
- i_ENABLE  in  1  run enable; low freezes the sequencer.
- i_IR_DATA  in  DATA_WIDTH  instruction register contents.
- i_ZERO_FLAG  in  1  ALU zero flag.
- i_CARRY_FLAG  in  1  ALU carry flag.
- i_NEG_FLAG  in  1  ALU negative flag.
- o_CLEAR  out  1  equals i_RESET (combinational).
- o_CLEAR_n  out  1  inverse of o_CLEAR.
- o_CONTROL_SIGNALS  out  CONTROL_WIDTH  control word for the current step.
- o_T_CYCLE  out  T_WIDTH  current step number.
- o_INSTR_DONE  out  1  high during the final step of an instruction.
- o_HALTED  out  1  sequencer is in the HALTED state.
- o_ILLEGAL  out  1  sticky flag: an undefined opcode was executed.

Behaviour:
- States: RUN, HALTED. The step counter T is meaningful in RUN only.
- Reset (sampled on the clock edge):
  - State = RUN, T = 0, o_ILLEGAL = 0, branch latch = 0.
  - While i_RESET is high, o_CONTROL_SIGNALS = 0 and o_INSTR_DONE = 0.
  - Reset mid-instruction abandons the instruction; the first cycle after reset is T0.
- Fetch steps, common to all instructions:
  - T0: PC_OUT | MAR_IN.
  - T1: RAM_OUT | IR_IN | PC_INC.
- Decode:
  - Decode from T2 uses the opcode field only; the low bits are ignored.
  - On the step marked "end", o_INSTR_DONE = 1 and T <= 0 on the next edge. Otherwise T <= T+1.
- Execute steps, per opcode:
  - 1 LDA: T2 PC_OUT|MAR_IN; T3 RAM_OUT|MAR_IN; T4 PC_INC|RAM_OUT|A_IN, end.
  - 2 ADD / 3 SUB: T2 PC_OUT|MAR_IN; T3 RAM_OUT|MAR_IN; T4 RAM_OUT|B_IN; T5 PC_INC|ALU_OUT|A_IN|FLAGS_UPDATE (SUB adds ALU_SUB), end.
  - 4 LDI: T2 PC_OUT|MAR_IN; T3 PC_INC|RAM_OUT|A_IN, end.
  - 5 ADDI / 6 SUBI: T2 PC_OUT|MAR_IN; T3 PC_INC|RAM_OUT|B_IN; T4 ALU_OUT|A_IN|FLAGS_UPDATE (SUBI adds ALU_SUB), end.
  - 7 STA: T2 PC_OUT|MAR_IN; T3 RAM_OUT|MAR_IN; T4 PC_INC|A_OUT|RAM_IN, end.
  - 8 JMP: T2 PC_OUT|MAR_IN; T3 PC_INC|RAM_OUT|JUMP, end.
- Conditional jumps (9 JZ, A JC, B JN):
  - At T2 the selected flag is latched into the branch latch; T3 uses the latch only, so a flag change after T2 has no effect.
  - Taken: T2 PC_OUT|MAR_IN; T3 PC_INC|RAM_OUT|JUMP, end.
  - Not taken: T2 control word 0; T3 PC_INC, end, so the operand byte is always skipped.
- Single-step instructions:
  - E OUT: T2 A_OUT|OUT_IN, end.
  - F HLT: T2 HALT, end. Next state is HALTED.
- Undefined opcodes (0, C, D): T2 control word 0, end, o_ILLEGAL <= 1. The flag stays set until reset.
- HALTED:
  - o_CONTROL_SIGNALS = HALT, o_HALTED = 1, T = 0, o_INSTR_DONE = 0.
  - Exit is by reset only.
- Freeze (i_ENABLE low in RUN):
  - T, state and latches hold.
  - o_CONTROL_SIGNALS = 0 and o_INSTR_DONE = 0.
  - o_T_CYCLE still shows the held step.
  - On re-enable, the held step issues its control word in full.
- i_ENABLE has no effect in HALTED or during reset. Reset wins over every other input.
- T never exceeds the last step of the current opcode. If T ever holds a value past that step, T <= 0 with a zero control word (defensive).

Test Plan:
- Reset then LDI (IR=0x40), i_ENABLE=1 -> T sequence 0,1,2,3,0; T3 word = PC_INC|RAM_OUT|A_IN; o_INSTR_DONE high only in T3.
- ADD (IR=0x25) -> 6 steps; T5 word = PC_INC|ALU_OUT|A_IN|FLAGS_UPDATE; low nibble ignored; next fetch begins the cycle after T5.
- JZ (IR=0x90) with ZERO=1 at T2, then ZERO=0 at T3 -> T3 = PC_INC|RAM_OUT|JUMP. Repeat with ZERO=0 at T2 -> T2 word = 0, T3 = PC_INC.
- IR=0xC0 -> T2 word = 0, o_ILLEGAL rises and stays 1 through later valid instructions until i_RESET.
- i_ENABLE low for 3 cycles at T3 of STA -> word = 0 and T=3 held; after re-enable, T3 = RAM_OUT|MAR_IN, then T4.
- HLT (IR=0xF0) -> o_HALTED=1 and HALT word held for 20 cycles with i_ENABLE toggling; i_RESET pulse -> next cycle T0 fetch word, o_HALTED=0.
